uart_fifo_ctrl: RTL and testbench
=================================

Name: uart_fifo_ctrl

Overview:
- Controller sitting around the UART TX byte FIFO.
- Shares the FIFO write port between two requesters, port 0 (CPU MMIO store path) and port 1 (debug/boot message source), using round-robin arbitration.
- Sequences the FIFO read side into the UART serializer through a start/busy handshake.
- Keeps a saturating count of transmitted bytes for the status register.

Parameters:
- DATA_W, 8, byte width on all data paths.
- CNT_W, 16, width of the tx_count status counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  DATA_W  requester 0 byte
- req0_ack  out  1  byte from requester 0 is written this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  DATA_W  requester 1 byte
- req1_ack  out  1  byte from requester 1 is written this cycle
- fifo_write_en  out  1  FIFO push strobe
- fifo_write_data  out  DATA_W  FIFO push data
- fifo_full  in  1  FIFO full flag
- fifo_read_en  out  1  FIFO pop strobe
- fifo_read_data  in  DATA_W  FIFO head byte, valid combinationally while not empty
- fifo_empty  in  1  FIFO empty flag
- drain_en  in  1  allow transmission; 0 pauses draining
- tx_start  out  1  one-cycle start pulse to the serializer
- tx_data  out  DATA_W  byte for the serializer, registered
- tx_busy  in  1  serializer busy
- tx_count  out  CNT_W  bytes handed to the serializer, saturating
- drain_busy  out  1  drain FSM not in IDLE

Behaviour:
- Reset is reset, synchronous, active-high; clock is clk. Reset values:
  - acks, fifo_write_en, fifo_read_en, tx_start and drain_busy all 0
  - tx_data = 0, tx_count = 0
  - priority pointer = port 0
  - FSM = IDLE
- Arbiter (combinational grant, no added latency):
  - A grant is possible only when fifo_full = 0.
  - Exactly one valid: that port is granted.
  - Both valid: the port named by the priority pointer wins.
  - On grant: fifo_write_en = 1, fifo_write_data = the winner's data, and the winner's ack = 1, all in the same cycle.
  - At most one ack per cycle. No ack while fifo_full = 1.
  - Requesters hold valid and data stable until ack. Data is consumed on the clock edge where ack = 1.
  - Pointer update, registered on each grant: pointer becomes the other port (the last winner drops to lowest priority). With no grant the pointer holds.
  - With both ports continuously valid and the FIFO not full, grants alternate 0,1,0,1...
- Drain FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - IDLE -> LOAD when drain_en = 1, fifo_empty = 0 and tx_busy = 0.
  - LOAD lasts one cycle: fifo_read_en = 1, and tx_data <= fifo_read_data together with tx_start = 1, registered, so the serializer sees both on the next cycle. tx_count increments, saturating at all-ones. -> WAIT_BUSY.
  - WAIT_BUSY: tx_start is high during this state's first cycle only. Stay until tx_busy = 1, then -> WAIT_DONE. If tx_busy is still 0 after 4 cycles, -> IDLE (serializer missed the byte; the byte is lost and still counted).
  - WAIT_DONE: stay while tx_busy = 1; -> IDLE when tx_busy = 0.
  - Throughput: at most one pop per serializer frame; back-to-back bytes restart from IDLE.
  - Deasserting drain_en mid-byte does not abort it; the current byte completes and the FSM then holds in IDLE.
  - drain_busy = (state != IDLE).
- Simultaneous push and pop in one cycle is legal. The FIFO handles the count; the controller drives both strobes independently.
- Reset asserted mid-byte: the FSM returns to IDLE the next cycle and tx_start is not reissued. The serializer and FIFO reset on the same reset.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_W
  - the drain FSM state enum (IDLE, LOAD, WAIT_BUSY, WAIT_DONE)
  - WAIT_BUSY_TIMEOUT = 4
- One natural sub-module: uart_rr_arbiter2 (two-port round-robin grant plus pointer).
- The drain FSM and counter stay in the top module.

Test Plan:
- Reset, then req0_valid with data 0x41, FIFO not full -> same cycle req0_ack = 1, fifo_write_en = 1, fifo_write_data = 0x41; pointer moves to port 1.
- Both requesters valid, data 0xA0 and 0xB0, held for 4 cycles -> grant order port 0, 1, 0, 1; FIFO receives A0, B0, A0, B0.
- fifo_full = 1 with both requesters valid -> no acks and fifo_write_en = 0. Release full -> grant goes to the pointer's port.
- FIFO holding 0x55, drain_en = 1, model serializer raises busy 1 cycle after start and holds it 10 cycles:
  - one fifo_read_en pulse, then tx_start with tx_data = 0x55 on the next cycle
  - tx_count = 1
  - drain_busy stays high until busy falls
- Serializer never raises busy -> FSM returns to IDLE after 4 WAIT_BUSY cycles, then pops and starts the next byte.
- drain_en dropped during WAIT_DONE, with 3 bytes queued -> the current byte finishes and no further pops occur. Re-raise drain_en -> the remaining bytes drain in order.
- tx_count preset near saturation (CNT_W = 4) -> after 15 transmitted bytes it holds at 15.
- Reset pulsed during WAIT_DONE -> tx_count = 0, state IDLE, no spurious tx_start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX FIFO controller.
package uart_pkg;

    localparam int unsigned DATA_W            = 8;
    localparam int unsigned WAIT_BUSY_TIMEOUT = 4;
    localparam int unsigned WAIT_CNT_W        = $clog2(WAIT_BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } drain_state_e;

    // One byte offered to (or pushed into) the TX FIFO write port.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/uart_rr_arbiter2.sv
// Two-port round-robin arbiter for the TX FIFO write port; grant is combinational,
// the priority pointer is registered.
module uart_rr_arbiter2
    import uart_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    enable,
    input  wr_req_t req0,
    input  wr_req_t req1,
    input  logic    fifo_full,
    output logic    grant0_c,
    output logic    grant1_c,
    output wr_req_t push_c
);

    // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic prio1;

    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        push_c   = '0;
        if (enable && !fifo_full) begin
            if (req0.valid && (!req1.valid || !prio1)) begin
                grant0_c = 1'b1;
            end else if (req1.valid) begin
                grant1_c = 1'b1;
            end
        end
        push_c.valid = grant0_c | grant1_c;
        if (grant0_c) begin
            push_c.data = req0.data;
        end else if (grant1_c) begin
            push_c.data = req1.data;
        end
    end

    // The last winner drops to lowest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio1 <= 1'b0;
        end else if (grant0_c) begin
            prio1 <= 1'b1;
        end else if (grant1_c) begin
            prio1 <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART TX FIFO controller: arbitrates two byte sources into the FIFO and drains
// the FIFO into the serializer, counting transmitted bytes.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ack,
    output logic              fifo_write_en,
    output logic [DATA_W-1:0] fifo_write_data,
    input  logic              fifo_full,
    output logic              fifo_read_en,
    input  logic [DATA_W-1:0] fifo_read_data,
    input  logic              fifo_empty,
    input  logic              drain_en,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [CNT_W-1:0]  tx_count,
    output logic              drain_busy
);

    localparam logic [CNT_W-1:0]      CNT_MAX      = '1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_END = WAIT_CNT_W'(WAIT_BUSY_TIMEOUT - 1);

    wr_req_t req0_s;
    wr_req_t req1_s;
    wr_req_t push_c;

    assign req0_s = {req0_valid, req0_data};
    assign req1_s = {req1_valid, req1_data};

    uart_rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .enable    (!reset),
        .req0      (req0_s),
        .req1      (req1_s),
        .fifo_full (fifo_full),
        .grant0_c  (req0_ack),
        .grant1_c  (req1_ack),
        .push_c    (push_c)
    );

    assign fifo_write_en   = push_c.valid;
    assign fifo_write_data = push_c.data;

    drain_state_e          state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Drain sequencer: one pop per serializer frame, restarting from IDLE each byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            fifo_read_en <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            tx_count     <= '0;
            drain_busy   <= 1'b0;
        end else begin
            fifo_read_en <= 1'b0;
            tx_start     <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain_en && !fifo_empty && !tx_busy) begin
                        state        <= LOAD;
                        fifo_read_en <= 1'b1;
                        drain_busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    tx_data  <= fifo_read_data;
                    tx_start <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                    if (tx_count != CNT_MAX) begin
                        tx_count <= tx_count + CNT_W'(1);
                    end
                end
                WAIT_BUSY: begin
                    // A serializer that never goes busy lost the byte; give up and move on.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == WAIT_CNT_END) begin
                        state      <= IDLE;
                        drain_busy <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state      <= IDLE;
                        drain_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    drain_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl with a queue-based FIFO and serializer model.
module tb_uart_fifo_ctrl;

    localparam int unsigned DW      = 8;
    localparam int unsigned CW      = 4;
    localparam int          DEPTH   = 8;
    localparam int          CNT_SAT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ack, req1_ack;
    logic          fifo_write_en, fifo_full, fifo_read_en, fifo_empty;
    logic [DW-1:0] fifo_write_data, fifo_read_data;
    logic          drain_en, tx_start, tx_busy, drain_busy;
    logic [DW-1:0] tx_data;
    logic [CW-1:0] tx_count;

    uart_fifo_ctrl #(.CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_data       (req0_data),
        .req0_ack        (req0_ack),
        .req1_valid      (req1_valid),
        .req1_data       (req1_data),
        .req1_ack        (req1_ack),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .fifo_full       (fifo_full),
        .fifo_read_en    (fifo_read_en),
        .fifo_read_data  (fifo_read_data),
        .fifo_empty      (fifo_empty),
        .drain_en        (drain_en),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .tx_busy         (tx_busy),
        .tx_count        (tx_count),
        .drain_busy      (drain_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sent[$];
    logic          prio;          // 1: port 1 wins a tie
    logic          pend_valid;
    logic [DW-1:0] pend_byte;
    int            pops;
    bit            force_full, auto_req, ser_mute;
    int            ser_delay, ser_len, dly_cnt, busy_cnt;
    logic          prev_drain_en;

    // Values observed at the last negedge
    logic          o_ack0, o_ack1, o_we, o_re, o_start, o_dbusy, o_busy, o_reset;
    logic [DW-1:0] o_wdata, o_tdata;
    logic [CW-1:0] o_cnt;
    logic          e_g0, e_g1;
    logic [DW-1:0] e_wdata;

    // One clock: check at negedge, then advance the models just after posedge.
    task automatic tick();
        int exp_cnt;
        @(negedge clk);
        o_ack0 = req0_ack;  o_ack1 = req1_ack;  o_we = fifo_write_en;
        o_wdata = fifo_write_data;  o_re = fifo_read_en;  o_start = tx_start;
        o_tdata = tx_data;  o_cnt = tx_count;  o_dbusy = drain_busy;
        o_busy = tx_busy;  o_reset = reset;

        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!reset && !fifo_full) begin
            if (req0_valid && req1_valid) begin
                if (prio) e_g1 = 1'b1; else e_g0 = 1'b1;
            end else if (req0_valid) e_g0 = 1'b1;
            else if (req1_valid) e_g1 = 1'b1;
        end
        e_wdata = e_g0 ? req0_data : req1_data;

        check("ack0", 32'(o_ack0), 32'(e_g0));
        check("ack1", 32'(o_ack1), 32'(e_g1));
        check("write_en", 32'(o_we), 32'(e_g0 | e_g1));
        if (e_g0 | e_g1) check("write_data", 32'(o_wdata), 32'(e_wdata));
        check("tx_start", 32'(o_start), 32'(pend_valid));
        if (pend_valid) check("tx_data", 32'(o_tdata), 32'(pend_byte));
        exp_cnt = (pops > CNT_SAT) ? CNT_SAT : pops;
        check("tx_count", 32'(o_cnt), 32'(exp_cnt));
        if (o_re) begin
            check("pop_nonempty", 32'(fifo_empty), 32'(0));
            check("pop_ser_idle", 32'(tx_busy), 32'(0));
            check("pop_drain_en", 32'(prev_drain_en), 32'(1));
        end
        if (o_start) sent.push_back(o_tdata);
        prev_drain_en = drain_en && !reset;

        @(posedge clk);
        #1;
        if (o_reset) begin
            fifo_q.delete();
            prio = 1'b0;  pend_valid = 1'b0;  pops = 0;
            tx_busy = 1'b0;  dly_cnt = 0;  busy_cnt = 0;
        end else begin
            pend_valid = 1'b0;
            if (o_re && fifo_q.size() > 0) begin
                pend_valid = 1'b1;
                pend_byte  = fifo_q.pop_front();
            end
            if (o_re) pops++;
            if (e_g0 | e_g1) begin
                fifo_q.push_back(e_wdata);
                prio = e_g0;
            end
            if (tx_busy) begin
                busy_cnt--;
                if (busy_cnt <= 0) tx_busy = 1'b0;
            end
            if (o_start && !ser_mute) dly_cnt = ser_delay;
            if (dly_cnt > 0) begin
                dly_cnt--;
                if (dly_cnt == 0) begin
                    tx_busy  = 1'b1;
                    busy_cnt = ser_len;
                end
            end
            if (auto_req) begin
                if (e_g0 || !req0_valid) begin
                    req0_valid = ($urandom_range(0, 2) != 0);
                    req0_data  = DW'($urandom);
                end
                if (e_g1 || !req1_valid) begin
                    req1_valid = ($urandom_range(0, 2) != 0);
                    req1_data  = DW'($urandom);
                end
            end
        end
        fifo_full      = force_full || (fifo_q.size() >= DEPTH);
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = fifo_empty ? DW'(0) : fifo_q[0];
    endtask

    task automatic wait_pop(input int bound, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!o_re && waited < bound);
        check("pop_seen", 32'(o_re), 32'(1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sent.delete();
    endtask

    task automatic push0(input logic [DW-1:0] b);
        req0_valid = 1'b1;
        req0_data  = b;
        tick();
        check("push0_ack", 32'(o_ack0), 32'(1));
        req0_valid = 1'b0;
    endtask

    initial begin
        int w, hi, gap, starts;
        reset = 1'b1;  req0_valid = 1'b0;  req1_valid = 1'b0;
        req0_data = '0;  req1_data = '0;  drain_en = 1'b0;
        fifo_full = 1'b0;  fifo_empty = 1'b1;  fifo_read_data = '0;  tx_busy = 1'b0;
        prio = 1'b0;  pend_valid = 1'b0;  pend_byte = '0;  pops = 0;
        force_full = 0;  auto_req = 0;  ser_mute = 0;
        ser_delay = 1;  ser_len = 10;  dly_cnt = 0;  busy_cnt = 0;  prev_drain_en = 1'b0;

        tick();
        tick();
        check("rst_drain_busy", 32'(o_dbusy), 32'(0));
        check("rst_tx_start", 32'(o_start), 32'(0));
        check("rst_tx_data", 32'(o_tdata), 32'(0));
        check("rst_tx_count", 32'(o_cnt), 32'(0));
        check("rst_read_en", 32'(o_re), 32'(0));
        reset = 1'b0;

        // Single requester is granted in the same cycle; pointer then favours port 1
        req0_valid = 1'b1;  req0_data = 8'h41;
        tick();
        check("t1_ack0", 32'(o_ack0), 32'(1));
        check("t1_we", 32'(o_we), 32'(1));
        check("t1_wdata", 32'(o_wdata), 32'h41);
        req0_data = 8'h10;  req1_valid = 1'b1;  req1_data = 8'h20;
        tick();
        check("t1_ptr_port1", 32'(o_ack1), 32'(1));
        req0_valid = 1'b0;  req1_valid = 1'b0;

        // Both continuously valid: alternate 0,1,0,1
        pulse_reset();
        req0_valid = 1'b1;  req0_data = 8'hA0;  req1_valid = 1'b1;  req1_data = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t2_grant1_%0d", i), 32'(o_ack1), 32'(i % 2));
            check($sformatf("t2_wdata_%0d", i), 32'(o_wdata), (i % 2 == 1) ? 32'hB0 : 32'hA0);
        end

        // Full blocks all grants; release goes to the pointer's port (0)
        force_full = 1;  fifo_full = 1'b1;
        tick();
        check("t3_full_ack0", 32'(o_ack0), 32'(0));
        check("t3_full_ack1", 32'(o_ack1), 32'(0));
        check("t3_full_we", 32'(o_we), 32'(0));
        tick();
        force_full = 0;  fifo_full = (fifo_q.size() >= DEPTH);
        tick();
        check("t3_release_ack0", 32'(o_ack0), 32'(1));
        req0_valid = 1'b0;  req1_valid = 1'b0;

        // One byte drained with a well-behaved serializer
        pulse_reset();
        push0(8'h55);
        ser_delay = 1;  ser_len = 10;  drain_en = 1'b1;
        wait_pop(20, w);
        hi = o_dbusy ? 1 : 0;
        tick();
        check("t4_start", 32'(o_start), 32'(1));
        check("t4_data", 32'(o_tdata), 32'h55);
        check("t4_count", 32'(o_cnt), 32'(1));
        if (o_dbusy) hi++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_busy) check("t4_dbusy_while_busy", 32'(o_dbusy), 32'(1));
            if (!o_dbusy) break;
            hi++;
        end
        check("t4_dbusy_len", 32'(hi), 32'(13));
        check("t4_pops", 32'(pops), 32'(1));

        // Serializer never goes busy: 4 WAIT_BUSY cycles, IDLE, next pop
        drain_en = 1'b0;
        pulse_reset();
        push0(8'h61);
        push0(8'h62);
        ser_mute = 1;  drain_en = 1'b1;
        wait_pop(20, w);
        wait_pop(20, gap);
        check("t5_gap", 32'(gap), 32'(6));
        for (int i = 0; i < 8; i++) tick();
        check("t5_idle", 32'(o_dbusy), 32'(0));
        check("t5_count", 32'(o_cnt), 32'(2));
        check("t5_order0", 32'(sent[0]), 32'h61);
        check("t5_order1", 32'(sent[1]), 32'h62);
        ser_mute = 0;

        // drain_en dropped in WAIT_DONE: current byte completes, then hold
        drain_en = 1'b0;
        pulse_reset();
        push0(8'h71);
        push0(8'h72);
        push0(8'h73);
        ser_delay = 1;  ser_len = 8;  drain_en = 1'b1;
        wait_pop(20, w);
        for (int i = 0; i < 10 && !o_busy; i++) tick();
        check("t6_busy_seen", 32'(o_busy), 32'(1));
        drain_en = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("t6_held_pops", 32'(pops), 32'(1));
        check("t6_held_idle", 32'(o_dbusy), 32'(0));
        drain_en = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        check("t6_pops", 32'(pops), 32'(3));
        check("t6_order0", 32'(sent[0]), 32'h71);
        check("t6_order1", 32'(sent[1]), 32'h72);
        check("t6_order2", 32'(sent[2]), 32'h73);

        // Counter saturation at 15 with CNT_W = 4
        pulse_reset();
        ser_delay = 1;  ser_len = 1;  drain_en = 1'b1;
        req0_valid = 1'b1;  req0_data = 8'h00;
        for (int i = 0; i < 400 && pops < 17; i++) begin
            tick();
            if (e_g0) req0_data = req0_data + 8'h01;
        end
        req0_valid = 1'b0;
        check("t7_pops_reached", 32'(pops >= 17), 32'(1));
        tick();
        tick();
        check("t7_saturated", 32'(o_cnt), 32'(CNT_SAT));

        // Reset during WAIT_DONE
        pulse_reset();
        push0(8'h99);
        ser_delay = 1;  ser_len = 10;
        wait_pop(20, w);
        for (int i = 0; i < 10 && !o_busy; i++) tick();
        tick();
        tick();
        check("t8_in_flight", 32'(o_dbusy), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("t8_count", 32'(o_cnt), 32'(0));
        check("t8_idle", 32'(o_dbusy), 32'(0));
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_start) starts++;
        end
        check("t8_no_start", 32'(starts), 32'(0));

        // Randomized traffic against the model
        pulse_reset();
        auto_req = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) drain_en = ~drain_en;
            force_full = ($urandom_range(0, 9) == 0);
            if (!tx_busy && dly_cnt == 0) begin
                ser_delay = $urandom_range(1, 3);
                ser_len   = $urandom_range(1, 6);
                ser_mute  = ($urandom_range(0, 7) == 0);
            end
            fifo_full = force_full || (fifo_q.size() >= DEPTH);
            tick();
        end
        auto_req = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
